dir_fsm: RTL and testbench



---
 rtl/dir_pkg.sv | 45 ++++
 rtl/btn_sync.sv | 30 +++
 rtl/dir_fsm.sv | 58 +++++
 tb/tb_dir_fsm.sv | 106 ++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// rtl/dir_pkg.sv - shared state encoding, reversal check and output decode for dir_fsm
package dir_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_state_t;

    // Output vector order: {onoffx, onoffy, horizontal, verticle}
    localparam logic [3:0] OUT_IDLE  = 4'b0000;
    localparam logic [3:0] OUT_UP    = 4'b0100;
    localparam logic [3:0] OUT_DOWN  = 4'b0101;
    localparam logic [3:0] OUT_LEFT  = 4'b1000;
    localparam logic [3:0] OUT_RIGHT = 4'b1010;

    function automatic logic is_opposite(input dir_state_t a, input dir_state_t b);
        return ((a == UP)   && (b == DOWN))  || ((a == DOWN)  && (b == UP)) ||
               ((a == LEFT) && (b == RIGHT)) || ((a == RIGHT) && (b == LEFT));
    endfunction

    function automatic logic [3:0] dir_outputs(input dir_state_t s);
        case (s)
            UP:      return OUT_UP;
            DOWN:    return OUT_DOWN;
            LEFT:    return OUT_LEFT;
            RIGHT:   return OUT_RIGHT;
            default: return OUT_IDLE;
        endcase
    endfunction

    // Request vector order: {up, down, left, right}; caller guarantees one-hot
    function automatic dir_state_t req_to_state(input logic [3:0] req);
        case (req)
            4'b1000: return UP;
            4'b0100: return DOWN;
            4'b0010: return LEFT;
            4'b0001: return RIGHT;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - N-stage 4-bit button synchronizer, pass-through when N is 0
module btn_sync #(
    parameter int N = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    generate
        if (N == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_sync
            logic [3:0] r_chain [N] = '{default: 4'b0000};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < N; i++) r_chain[i] <= 4'b0000;
                end else begin
                    r_chain[0] <= i_d;
                    for (int i = 1; i < N; i++) r_chain[i] <= r_chain[i-1];
                end
            end

            assign o_q = r_chain[N-1];
        end
    endgenerate

endmodule

// File: rtl/dir_fsm.sv
// rtl/dir_fsm.sv - light-cycle heading FSM: one-hot button requests, no 180-degree reversals
module dir_fsm
    import dir_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic onoffx,
    output logic onoffy,
    output logic horizontal,
    output logic verticle
);

    logic [3:0] w_req;
    logic       w_req_valid;
    dir_state_t w_req_state;
    dir_state_t w_next;

    dir_state_t r_state = IDLE;
    logic [3:0] r_out   = OUT_IDLE;

    btn_sync #(.N(SYNC_STAGES)) u_btn_sync (
        .clk (clk),
        .rst (reset),
        .i_d ({up, down, left, right}),
        .o_q (w_req)
    );

    assign w_req_valid = $onehot(w_req);
    assign w_req_state = req_to_state(w_req);

    always_comb begin
        w_next = r_state;
        if (w_req_valid) begin
            if (r_state == IDLE || !is_opposite(r_state, w_req_state))
                w_next = w_req_state;
        end
    end

    // Outputs are registered from the next state so they stay a pure function of r_state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_out   <= OUT_IDLE;
        end else begin
            r_state <= w_next;
            r_out   <= dir_outputs(w_next);
        end
    end

    assign {onoffx, onoffy, horizontal, verticle} = r_out;

endmodule

// File: tb/tb_dir_fsm.sv
// tb/tb_dir_fsm.sv - directed self-checking bench for dir_fsm (SYNC_STAGES 0 and 2)
module tb_dir_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b0, u0 = 1'b0, d0 = 1'b0, l0 = 1'b0, r0 = 1'b0;
    logic ox0, oy0, h0, v0;
    logic rst2 = 1'b0, u2 = 1'b0, d2 = 1'b0, l2 = 1'b0, r2 = 1'b0;
    logic ox2, oy2, h2, v2;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    dir_fsm #(.SYNC_STAGES(0)) u_dut0 (
        .clk(clk), .reset(rst0), .up(u0), .down(d0), .left(l0), .right(r0),
        .onoffx(ox0), .onoffy(oy0), .horizontal(h0), .verticle(v0)
    );

    dir_fsm #(.SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .reset(rst2), .up(u2), .down(d2), .left(l2), .right(r2),
        .onoffx(ox2), .onoffy(oy2), .horizontal(h2), .verticle(v2)
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Drive {up,down,left,right} just after an edge, then check 1ns after the following edge
    task automatic step0(input string tag, input logic [3:0] req, input logic [3:0] exp);
        {u0, d0, l0, r0} = req;
        @(posedge clk);
        #1;
        check_eq(tag, {ox0, oy0, h0, v0}, exp);
    endtask

    initial begin
        // Power-up without reset
        @(posedge clk); @(posedge clk); #1;
        check_eq("powerup0", {ox0, oy0, h0, v0}, 4'b0000);
        check_eq("powerup2", {ox2, oy2, h2, v2}, 4'b0000);

        step0("idle_right",   4'b0001, 4'b1010);
        step0("rev_left",     4'b0010, 4'b1010);
        step0("perp_down",    4'b0100, 4'b0101);
        step0("rev_up",       4'b1000, 4'b0101);

        step0("perp_left",    4'b0010, 4'b1000);
        step0("rev_right",    4'b0001, 4'b1000);
        step0("none_hold",    4'b0000, 4'b1000);
        step0("perp_up",      4'b1000, 4'b0100);
        step0("up_right",     4'b0001, 4'b1010);
        step0("right_up",     4'b1000, 4'b0100);
        step0("up_left",      4'b0010, 4'b1000);
        step0("left_rev",     4'b0001, 4'b1000);

        step0("to_up",        4'b1000, 4'b0100);
        step0("to_right",     4'b0001, 4'b1010);
        step0("multi_1100",   4'b1100, 4'b1010);
        step0("multi_1111",   4'b1111, 4'b1010);
        for (int i = 0; i < 5; i++) step0("rev_held", 4'b0010, 4'b1010);
        step0("after_rev",    4'b0100, 4'b0101);
        step0("to_left",      4'b0010, 4'b1000);

        // Asynchronous reset mid-cycle while in LEFT, right held through release
        #3;
        {u0, d0, l0, r0} = 4'b0001;
        rst0 = 1'b1;
        #1;
        check_eq("async_rst", {ox0, oy0, h0, v0}, 4'b0000);
        @(posedge clk); #1;
        check_eq("rst_held", {ox0, oy0, h0, v0}, 4'b0000);
        #2 rst0 = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst", {ox0, oy0, h0, v0}, 4'b1010);

        // Two-stage synchronizer latency
        {u2, d2, l2, r2} = 4'b0100;
        @(posedge clk); #1;
        check_eq("sync_e1", {ox2, oy2, h2, v2}, 4'b0000);
        @(posedge clk); #1;
        check_eq("sync_e2", {ox2, oy2, h2, v2}, 4'b0000);
        @(posedge clk); #1;
        check_eq("sync_e3", {ox2, oy2, h2, v2}, 4'b0101);

        // A request caught in the synchronizer must not survive reset
        {u2, d2, l2, r2} = 4'b0010;
        @(posedge clk); #1;
        check_eq("sync_inflt", {ox2, oy2, h2, v2}, 4'b0101);
        {u2, d2, l2, r2} = 4'b0000;
        rst2 = 1'b1;
        #1;
        check_eq("sync_rst", {ox2, oy2, h2, v2}, 4'b0000);
        #2 rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("sync_stale", {ox2, oy2, h2, v2}, 4'b0000);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
